// File: rtl/display_scan_pkg.sv
// Shared types and default timing constants for the 7-segment scan controller.
package display_scan_pkg;

  localparam int unsigned DIV_DEFAULT = 50000;
  localparam int unsigned GAP_DEFAULT = 2;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    SLOT_GAP = 1'b0,
    SLOT_ON  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed NDIG-digit scan controller with shadow value, ready/load handshake and blank gaps.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl
  import display_scan_pkg::*;
#(
  parameter int unsigned NDIG = 4,
  parameter int unsigned DIV  = DIV_DEFAULT,
  parameter int unsigned GAP  = GAP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic              blank_all,
  output logic              ready,
  output logic [3:0]        nib,
  output logic [NDIG-1:0]   an,
  output logic              seg_en
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned VAL_W = 4 * NDIG;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(GAP);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG - 1);
  localparam slot_state_t STATE_RST = (GAP > 0) ? SLOT_GAP : SLOT_ON;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  slot_state_t      state_q, state_d;
  logic [VAL_W-1:0] disp_q, disp_d;
  logic [VAL_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             ready_q, ready_d;
  nibble_t          nib_q, nib_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic             seg_en_q, seg_en_d;

  logic             frame_start;
  logic             accept;
  logic             commit;
  logic [NDIG-1:0]  show;

`ifdef DISPLAY_SCAN_LZB_EN
  logic             nz_seen;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= STATE_RST;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ready_q  <= 1'b1;
      nib_q    <= '0;
      an_q     <= '0;
      seg_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ready_q  <= ready_d;
      nib_q    <= nib_d;
      an_q     <= an_d;
      seg_en_q <= seg_en_d;
    end
  end

  // Next state: slot position, handshake and frame-aligned commit
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
    state_d = (cnt_d < CNT_GAP) ? SLOT_GAP : SLOT_ON;

    // Commit lands on the first cycle of a frame so digit 0 already uses the new value.
    frame_start = (cnt_q == '0) && (idx_q == '0);
    accept      = load && ready_q;
    commit      = frame_start && pend_v_q;

    if (commit) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (accept) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end
  end

  // Output decode for the registered pins
  always_comb begin
    show     = '1;
    nib_d    = '0;
    an_d     = '0;
    seg_en_d = 1'b0;
    ready_d  = ~pend_v_d;

`ifdef DISPLAY_SCAN_LZB_EN
    nz_seen = 1'b0;
    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      nz_seen = nz_seen || (disp_d[4*k +: 4] != 4'h0);
      show[k] = nz_seen || (k == 0);
    end
`endif

    for (int k = 0; k < int'(NDIG); k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_d = disp_d[4*k +: 4];
        if (state_q == SLOT_ON && !blank_all && show[k]) begin
          an_d[k]  = 1'b1;
          seg_en_d = 1'b1;
        end
      end
    end
  end

  assign ready  = ready_q;
  assign nib    = nib_q;
  assign an     = an_q;
  assign seg_en = seg_en_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: directed test-plan scenarios followed by randomized traffic.
module tb_display_scan_ctrl;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIV   = 8;
  localparam int unsigned GAP   = 2;
  localparam int unsigned FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_all = 1'b0;
  logic        ready;
  logic [3:0]  nib;
  logic [3:0]  an;
  logic        seg_en;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .blank_all (blank_all),
    .ready     (ready),
    .nib       (nib),
    .an        (an),
    .seg_en    (seg_en)
  );

  typedef struct {
    logic [3:0] an;
    logic [3:0] nib;
    logic       seg_en;
    logic       ready;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: absolute cycle count since reset release plus shown/pending values.
  int          m_n    = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv   = 1'b0;

  function automatic bit digit_lit(input logic [15:0] v, input int d);
`ifdef DISPLAY_SCAN_LZB_EN
    return (d == 0) || ((v >> (4 * d)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic step(input bit r, input bit l, input logic [15:0] v, input bit b);
    exp_t e;
    int   pos;
    int   dig;
    bit   acc;
    bit   com;
    bit   on;
    @(negedge clk);
    rst       = r;
    load      = l;
    value     = v;
    blank_all = b;
    if (r) begin
      m_n    = 0;
      m_disp = '0;
      m_pend = '0;
      m_pv   = 1'b0;
      e.an = 4'h0; e.nib = 4'h0; e.seg_en = 1'b0; e.ready = 1'b1; e.cyc = -1;
    end else begin
      pos = m_n % FRAME;
      dig = pos / DIV;
      acc = l && !m_pv;
      com = (pos == 0) && m_pv;
      if (com) begin
        m_disp = m_pend;
        m_pv   = 1'b0;
      end
      if (acc) begin
        m_pend = v;
        m_pv   = 1'b1;
      end
      on       = ((pos % DIV) >= GAP) && !b && digit_lit(m_disp, dig);
      e.nib    = 4'(m_disp >> (4 * dig));
      e.an     = on ? 4'(1 << dig) : 4'h0;
      e.seg_en = on;
      e.ready  = !m_pv;
      e.cyc    = m_n;
      m_n++;
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req, input int cyc);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents new registered outputs
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("an",     an,              mon_e.an,              mon_e.cyc);
        chk("nib",    nib,             mon_e.nib,             mon_e.cyc);
        chk("seg_en", {3'b0, seg_en},  {3'b0, mon_e.seg_en},  mon_e.cyc);
        chk("ready",  {3'b0, ready},   {3'b0, mon_e.ready},   mon_e.cyc);
      end
    end
  end

  logic [15:0] rv;
  bit          rb;

  initial begin
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Load 1234, ignored BEEF while busy, blank window 41..61
    for (int c = 0; c < 100; c++)
      step(1'b0, (c == 6) || (c == 12),
           (c == 6) ? 16'h1234 : ((c == 12) ? 16'hBEEF : 16'h0),
           (c >= 41) && (c <= 61));

    // Reset while a load is pending: pending value must never appear
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 90; c++)
      step(c == 20, c == 6, (c == 6) ? 16'h9876 : 16'h0, 1'b0);

    // Leading-zero patterns
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 160; c++)
      step(1'b0, (c == 3) || (c == 80), (c == 3) ? 16'h0050 : 16'h0000, 1'b0);

    // Randomized traffic
    rb = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) rb = !rb;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0, rv, rb);
    end

    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d required=0 pending expectations", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
